r_peak_detector: RTL and testbench
==================================

Name: r_peak_detector

Overview:
- Downstream consumer of the ECG front end's integrated-energy stream (dn) and adaptive threshold.
- Detects QRS/R-peak events, reports the peak amplitude and the RR interval in samples, and flags missed beats.
- Output feeds heart-rate and display logic.
- Sample-rate domain: one sample per in_valid pulse on clk.

Parameters:
DATA_W, 32, width of dn/threshold/peak_amp
RR_W, 16, width of sample timestamp and RR interval
REFRACT_SAMPLES, 50, refractory length in samples (200 ms at 250 Hz)
MAX_RR, 500, samples without a peak before beat_missed fires (2 s at 250 Hz)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  one-cycle strobe, dn/threshold valid
dn  in  DATA_W  integrated signal sample, unsigned
threshold  in  DATA_W  detection threshold, unsigned, sampled with dn
peak_valid  out  1  one-cycle pulse, peak detected
peak_amp  out  DATA_W  max dn of the detected peak
rr_valid  out  1  one-cycle pulse with peak_valid when rr_interval is meaningful
rr_interval  out  RR_W  samples between this peak's max and the previous one's
beat_missed  out  1  one-cycle pulse on timeout
busy  out  1  high in ABOVE or REFRACT
rr_avg  out  RR_W  8-beat RR mean (see Optional Feature)

Behaviour:
- Reset is synchronous on rst_n=0. All outputs go to 0. State goes to SEARCH. All counters clear. first_peak flag is set.
- Reset mid-peak discards the pending peak; no pulse is emitted.
- ts: RR_W-bit free counter, +1 per in_valid, wraps modulo 2^RR_W.
- gap: counter of samples since the last peak max, +1 per in_valid, saturates at 2^RR_W-1.
- States are SEARCH, ABOVE and REFRACT. They change only on in_valid cycles.
- SEARCH, when dn > threshold (strict):
  - go to ABOVE;
  - max := dn, pos := ts, gap_at_max := gap.
- ABOVE, when dn > max: max := dn, pos := ts, gap_at_max := gap. Equal values keep the earlier position.
- ABOVE, when dn <= threshold: emit the peak and go to REFRACT with rcnt := REFRACT_SAMPLES-1.
- REFRACT: rcnt decrements per in_valid. When rcnt == 0 on an in_valid, go to SEARCH. Any dn is ignored in this state.
- Peak emission (registered, asserted the cycle after the closing in_valid):
  - peak_valid=1, peak_amp=max;
  - rr_interval = pos - last_pos (mod 2^RR_W);
  - rr_valid=1 unless first_peak is set or gap_at_max saturated;
  - then last_pos := pos, first_peak := 0, and gap restarts counting from the peak position.
- beat_missed: one pulse when gap reaches MAX_RR while in SEARCH. It re-arms only after the next peak. MAX_RR >= REFRACT_SAMPLES is required.
- Simultaneous threshold crossing and refractory expiry on the same in_valid: expiry wins. The sample is ignored and SEARCH evaluates the next sample.
- threshold changes while in ABOVE apply immediately to the exit test.
- in_valid low: nothing changes; output pulses still clear after one cycle.

Optional Feature:
- Macro: RR_AVG_EN.
- Defined:
  - 8-entry shift register of RR values, loaded on each rr_valid;
  - rr_avg = (sum of entries) >> 3, registered one cycle after rr_valid;
  - entries start at 0 after reset, so the first 7 averages are underestimates by design.
- Undefined: rr_avg is tied to 0 and no averaging logic is built.

Decomposition:
- Package ecg_pkg:
  - state enum codes (SEARCH=2'd0, ABOVE=2'd1, REFRACT=2'd2);
  - default constants for 250 Hz (REFRACT_SAMPLES, MAX_RR).
- Sub-module rr_averager (8-tap moving average) is instantiated only under RR_AVG_EN.
- The FSM and counters stay in the top module.

Test Plan:
- Reset is held 3 cycles, then dn=0 and threshold=100 for 10 samples -> all outputs 0, state SEARCH, no pulses.
- Samples 120, 300, 250, 90 with threshold=100 -> exactly one peak_valid, one cycle after the 90 sample. peak_amp=300, rr_valid=0 (first peak), busy high from the 120 sample.
- Two peaks with maxima 250 samples apart -> second peak_valid has rr_valid=1 and rr_interval=250. An above-threshold burst 20 samples after the first peak (inside refractory) produces no pulse.
- No crossing for 500 samples after a peak -> one beat_missed pulse at gap=500 and no repeat. A later peak re-arms it.
- Timestamp wrap: peak at ts=65500, next peak 100 samples later (ts=64) -> rr_interval=100, rr_valid=1.
- With RR_AVG_EN, 8 consecutive RR of 200 -> rr_avg=200 after the 8th. Reset asserted mid-ABOVE -> no peak_valid, outputs 0 the next cycle.

Source files
------------

// File: rtl/ecg_pkg.sv
// Shared types and 250 Hz defaults for the ECG R-peak detection path.
// State codes are fixed so they line up with debug taps elsewhere in the chain.
package ecg_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ABOVE   = 2'd1,
    REFRACT = 2'd2
  } state_t;

  localparam int ECG_REFRACT_SAMPLES = 50;   // 200 ms at 250 Hz
  localparam int ECG_MAX_RR          = 500;  // 2 s at 250 Hz
  localparam int RR_AVG_TAPS         = 8;

endpackage

// File: rtl/rr_averager.sv
// 8-tap moving average of RR intervals (only built when RR_AVG_EN is defined).
// avg updates one cycle after a load pulse; no backpressure, one load per beat.
`ifdef RR_AVG_EN
module rr_averager
  import ecg_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] rr,
  output logic [W-1:0] avg
);

  logic [W-1:0] taps [RR_AVG_TAPS];
  logic [W+2:0] sum_q;
  logic [W+2:0] sum_d;

  // Running sum: drop the oldest tap, add the newest.
  assign sum_d = sum_q - {3'b000, taps[RR_AVG_TAPS-1]} + {3'b000, rr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RR_AVG_TAPS; i++) taps[i] <= '0;
      sum_q <= '0;
      avg   <= '0;
    end else if (load) begin
      taps[0] <= rr;
      for (int i = 1; i < RR_AVG_TAPS; i++) taps[i] <= taps[i-1];
      sum_q <= sum_d;
      avg   <= sum_d[W+2:3];
    end
  end

endmodule
`endif

// File: rtl/r_peak_detector.sv
// R-peak detector: SEARCH/ABOVE/REFRACT on dn vs threshold; pulses appear one clk after the closing in_valid.
// No backpressure (strobe in, pulses out). Define RR_AVG_EN to build the 8-beat rr_avg, otherwise it is tied to 0.
module r_peak_detector
  import ecg_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int RR_W            = 16,
  parameter int REFRACT_SAMPLES = ECG_REFRACT_SAMPLES,
  parameter int MAX_RR          = ECG_MAX_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] dn,
  input  logic [DATA_W-1:0] threshold,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_amp,
  output logic              rr_valid,
  output logic [RR_W-1:0]   rr_interval,
  output logic              beat_missed,
  output logic              busy,
  output logic [RR_W-1:0]   rr_avg
);

  localparam logic [RR_W-1:0] REFR_LAST = RR_W'(REFRACT_SAMPLES - 1);
  localparam logic [RR_W-1:0] MAX_RR_V  = RR_W'(MAX_RR);
  localparam logic [RR_W-1:0] GAP_SAT   = '1;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [RR_W-1:0]     pos_q, pos_d;
  logic [RR_W-1:0]     gmax_q, gmax_d;
  logic [RR_W-1:0]     rcnt_q, rcnt_d;
  logic [RR_W-1:0]     gap_q, gap_d;
  logic [RR_W-1:0]     ts_q;
  logic [RR_W-1:0]     last_pos_q;
  logic                first_q;
  logic                armed_q, armed_d;
  logic                emit;
  logic                miss;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    pos_d   = pos_q;
    gmax_d  = gmax_q;
    rcnt_d  = rcnt_q;
    gap_d   = gap_q;
    armed_d = armed_q;
    emit    = 1'b0;
    miss    = 1'b0;
    if (in_valid) begin
      gap_d = (gap_q == GAP_SAT) ? gap_q : gap_q + 1'b1;
      unique case (state_q)
        SEARCH: begin
          if (armed_q && (gap_q == MAX_RR_V)) begin
            miss    = 1'b1;
            armed_d = 1'b0;
          end
          if (dn > threshold) begin
            state_d = ABOVE;
            max_d   = dn;
            pos_d   = ts_q;
            gmax_d  = gap_q;
          end
        end
        ABOVE: begin
          // Exit test first: a raised threshold closes the peak even on a larger sample.
          if (dn <= threshold) begin
            emit    = 1'b1;
            state_d = REFRACT;
            rcnt_d  = REFR_LAST;
            gap_d   = ts_q - pos_q + 1'b1;
            armed_d = 1'b1;
          end else if (dn > max_q) begin
            max_d  = dn;
            pos_d  = ts_q;
            gmax_d = gap_q;
          end
        end
        REFRACT: begin
          if (rcnt_q == '0) state_d = SEARCH;
          else              rcnt_d  = rcnt_q - 1'b1;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q       <= '0;
      pos_q       <= '0;
      gmax_q      <= '0;
      rcnt_q      <= '0;
      gap_q       <= '0;
      ts_q        <= '0;
      last_pos_q  <= '0;
      first_q     <= 1'b1;
      armed_q     <= 1'b1;
      peak_valid  <= 1'b0;
      peak_amp    <= '0;
      rr_valid    <= 1'b0;
      rr_interval <= '0;
      beat_missed <= 1'b0;
    end else begin
      max_q       <= max_d;
      pos_q       <= pos_d;
      gmax_q      <= gmax_d;
      rcnt_q      <= rcnt_d;
      gap_q       <= gap_d;
      armed_q     <= armed_d;
      if (in_valid) ts_q <= ts_q + 1'b1;
      peak_valid  <= emit;
      rr_valid    <= emit && !first_q && (gmax_q != GAP_SAT);
      beat_missed <= miss;
      if (emit) begin
        peak_amp    <= max_q;
        rr_interval <= pos_q - last_pos_q;
        last_pos_q  <= pos_q;
        first_q     <= 1'b0;
      end
    end
  end

  assign busy = (state_q == ABOVE) || (state_q == REFRACT);

`ifdef RR_AVG_EN
  rr_averager #(
    .W(RR_W)
  ) u_rr_averager (
    .clk  (clk),
    .rst_n(rst_n),
    .load (rr_valid),
    .rr   (rr_interval),
    .avg  (rr_avg)
  );
`else
  assign rr_avg = '0;
`endif

endmodule

// File: tb/tb_r_peak_detector.sv
// Directed bench for r_peak_detector: a sample-index model predicts every cycle's outputs,
// plus literal expectations at each scenario milestone.
module tb_r_peak_detector;

  localparam int DATA_W = 32;
  localparam int RR_W   = 16;
  localparam int REFR   = 50;
  localparam int MAXRR  = 500;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] dn = '0;
  logic [DATA_W-1:0] threshold = '0;
  logic              peak_valid;
  logic [DATA_W-1:0] peak_amp;
  logic              rr_valid;
  logic [RR_W-1:0]   rr_interval;
  logic              beat_missed;
  logic              busy;
  logic [RR_W-1:0]   rr_avg;

  always #5 clk = ~clk;

  r_peak_detector #(
    .DATA_W(DATA_W), .RR_W(RR_W), .REFRACT_SAMPLES(REFR), .MAX_RR(MAXRR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .dn(dn), .threshold(threshold),
    .peak_valid(peak_valid), .peak_amp(peak_amp), .rr_valid(rr_valid),
    .rr_interval(rr_interval), .beat_missed(beat_missed), .busy(busy), .rr_avg(rr_avg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: sample indices are unbounded integers counted from reset.
  longint idx, ref_idx, prev_idx, pk_idx;
  int     refr_left;
  bit     in_peak, have_prev, armed;
  logic [DATA_W-1:0] pk_max;
  int     hist [8];
  bit     avg_pend;
  int     avg_next;

  bit              e_pv, e_rrv, e_bm, e_busy, chk_vals;
  logic [DATA_W-1:0] e_amp;
  logic [RR_W-1:0]   e_rr, e_avg;

  // Observations for the literal milestone checks.
  int              n_peaks = 0;
  int              n_missed = 0;
  logic [DATA_W-1:0] last_amp = '0;
  logic [RR_W-1:0]   last_rr = '0;
  bit              last_rrv = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (model sample %0d, t=%0t)", name, act, exp, idx, $time);
    end
  endtask

  task automatic model_reset();
    idx = 0; ref_idx = 0; prev_idx = 0; pk_idx = 0;
    refr_left = 0; in_peak = 0; have_prev = 0; armed = 1;
    pk_max = '0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    avg_pend = 0; avg_next = 0;
    e_pv = 0; e_rrv = 0; e_bm = 0; e_busy = 0; chk_vals = 1;
    e_amp = '0; e_rr = '0; e_avg = '0;
  endtask

  task automatic model_tick();
    e_pv = 0; e_rrv = 0; e_bm = 0; chk_vals = 0;
    if (avg_pend) begin
      e_avg = RR_W'(avg_next);
      avg_pend = 0;
    end
  endtask

  task automatic model_sample(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] t);
    longint g;
    int sum;
    model_tick();
    if (refr_left > 0) begin
      refr_left--;
    end else if (in_peak) begin
      if (d <= t) begin
        g = pk_idx - ref_idx;
        if (g > 65535) g = 65535;
        e_pv  = 1;
        e_amp = pk_max;
        e_rr  = RR_W'(pk_idx - prev_idx);
        e_rrv = have_prev && (g != 65535);
        in_peak = 0; refr_left = REFR;
        prev_idx = pk_idx; ref_idx = pk_idx; have_prev = 1; armed = 1;
`ifdef RR_AVG_EN
        if (e_rrv) begin
          for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = int'(e_rr);
          sum = 0;
          for (int i = 0; i < 8; i++) sum += hist[i];
          avg_next = sum / 8;
          avg_pend = 1;
        end
`endif
      end else if (d > pk_max) begin
        pk_max = d; pk_idx = idx;
      end
    end else begin
      g = idx - ref_idx;
      if (g > 65535) g = 65535;
      if (armed && g == MAXRR) begin
        e_bm = 1; armed = 0;
      end
      if (d > t) begin
        in_peak = 1; pk_max = d; pk_idx = idx;
      end
    end
    e_busy = in_peak || (refr_left > 0);
    idx++;
  endtask

  task automatic compare();
    chk("peak_valid", peak_valid, e_pv);
    chk("rr_valid", rr_valid, e_rrv);
    chk("beat_missed", beat_missed, e_bm);
    chk("busy", busy, e_busy);
    chk("rr_avg", rr_avg, e_avg);
    if (e_pv || chk_vals) begin
      chk("peak_amp", peak_amp, e_amp);
      chk("rr_interval", rr_interval, e_rr);
    end
    if (peak_valid) begin
      n_peaks++; last_amp = peak_amp; last_rr = rr_interval; last_rrv = rr_valid;
    end
    if (beat_missed) n_missed++;
  endtask

  task automatic step(input bit r, input bit v, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] t);
    rst_n = r; in_valid = v; dn = d; threshold = t;
    if (!r) model_reset();
    else if (v) model_sample(d, t);
    else model_tick();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic samp(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] t);
    step(1'b1, 1'b1, d, t);
  endtask

  // Garbage on dn while in_valid is low must be ignored.
  task automatic idle();
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic quiet_to(input longint target);
    while (idx < target) samp(32'd0, 32'd100);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      samp(32'd0, 32'd100);
      idle();
    end
    chk("quiet_no_peak", n_peaks, 0);
    chk("quiet_no_miss", n_missed, 0);

    // First peak: max 300 at sample 11, closed by the 90 at sample 13.
    samp(32'd120, 32'd100);
    chk("busy_after_120", busy, 1);
    samp(32'd300, 32'd100);
    samp(32'd250, 32'd100);
    chk("no_pulse_before_close", n_peaks, 0);
    samp(32'd90, 32'd100);
    chk("pulse_after_90", peak_valid, 1);
    chk("first_amp", last_amp, 300);
    chk("first_rr_valid", last_rrv, 0);
    idle();
    chk("single_pulse", n_peaks, 1);

    // Burst 20 samples after the peak lands inside refractory.
    quiet_to(33);
    for (int i = 0; i < 5; i++) samp(32'd500, 32'd100);
    quiet_to(259);
    chk("refract_burst_ignored", n_peaks, 1);
    samp(32'd100, 32'd100);   // equal to threshold: no crossing
    samp(32'd150, 32'd100);
    samp(32'd400, 32'd100);   // max at sample 261
    samp(32'd400, 32'd100);   // equal: earlier position kept
    samp(32'd100, 32'd100);   // equal to threshold closes
    chk("second_amp", last_amp, 400);
    chk("second_rr", last_rr, 250);
    chk("second_rr_valid", last_rrv, 1);

    // Timeout: 500 samples after sample 261 -> miss at 761, no repeat.
    quiet_to(1400);
    chk("miss_once", n_missed, 1);
    samp(32'd300, 32'd100);
    samp(32'd250, 32'd300);   // raised threshold closes the peak
    chk("third_amp", last_amp, 300);
    chk("third_rr", last_rr, 1139);
    chk("third_rr_valid", last_rrv, 1);
    quiet_to(1950);
    chk("miss_rearmed", n_missed, 2);

    // Nine peaks 200 samples apart give eight RR values of 200.
    for (int k = 0; k < 9; k++) begin
      quiet_to(64'(2000 + 200 * k));
      samp(32'd300, 32'd100);
      samp(32'd0, 32'd100);
    end
    idle();
    idle();
    chk("avg_rr", last_rr, 200);
    chk("avg_rr_valid", last_rrv, 1);
`ifdef RR_AVG_EN
    chk("rr_avg_200", rr_avg, 200);
`else
    chk("rr_avg_off", rr_avg, 0);
`endif
    chk("peak_count", n_peaks, 12);

    // Reset while a peak is open, on a sample that would have closed it.
    quiet_to(3700);
    samp(32'd300, 32'd100);
    step(1'b0, 1'b1, 32'd50, 32'd100);
    chk("midpeak_reset_no_pulse", peak_valid, 0);
    chk("midpeak_reset_amp", peak_amp, 0);
    step(1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    idle();
    chk("midpeak_reset_discard", n_peaks, 12);

    // Timestamp wrap: peaks at sample 65500 and 65600 (ts 64).
    quiet_to(65500);
    samp(32'd200, 32'd100);
    samp(32'd50, 32'd100);
    chk("pre_wrap_rr_valid", last_rrv, 0);
    quiet_to(65600);
    samp(32'd200, 32'd100);
    samp(32'd50, 32'd100);
    chk("wrap_rr", last_rr, 100);
    chk("wrap_rr_valid", last_rrv, 1);
    chk("wrap_miss_count", n_missed, 3);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
